// File: rtl/udo_pkg.sv
// udo_pkg: shared flit-type constants, outport field position and FSM encodings.
package udo_pkg;
   localparam logic [1:0] HEAD = 2'b01;
   localparam logic [1:0] BODY = 2'b11;
   localparam logic [1:0] TAIL = 2'b10;
   localparam int OUTPORT_HI = 121;
   localparam int OUTPORT_LO = 120;
   typedef enum logic [1:0] {I_IDLE, I_WRITE, I_DROP} ing_state_t;
   typedef enum logic {E_IDLE, E_SEND} eg_state_t;
endpackage

// File: rtl/udo_fifo.sv
// udo_fifo: synchronous show-ahead FIFO with occupancy output.
// Ports: wr/wdata push, rd pop, rdata shows the head entry, empty flag,
// usedw occupancy (AW+1 bits so a full FIFO reads 2**AW).
module udo_fifo #(
   parameter int W  = 134,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr,
   input  logic [W-1:0]  wdata,
   input  logic          rd,
   output logic [W-1:0]  rdata,
   output logic          empty,
   output logic [AW:0]   usedw
);
   logic [W-1:0]  mem [2**AW];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_wr, do_rd;
   always_comb begin
      do_wr  = wr & ~cnt_q[AW];
      do_rd  = rd & (cnt_q != '0);
      wptr_d = wptr_q + AW'(do_wr);
      rptr_d = rptr_q + AW'(do_rd);
      cnt_d  = cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end
   always_ff @(posedge clk) begin
      if (do_wr) mem[wptr_q] <= wdata;
   end
   assign rdata = mem[rptr_q];
   assign empty = (cnt_q == '0);
   assign usedw = cnt_q;
endmodule

// File: rtl/udo.sv
// udo: egress output dispatcher steering packets into two per-port FIFOs.
// Ports: in_udo_* store-and-forward packet bus in; portN_* egress buses out
// with portN_ready backpressure; pktout_usedw_N data-FIFO occupancy;
// udo_*_cnt wrapping statistics counters.
module udo
   import udo_pkg::*;
#(
   parameter int DATA_AW       = 8,
   parameter int PKT_AW        = 4,
   parameter int MAX_PKT_FLITS = 96
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_udo_data_wr,
   input  logic [133:0] in_udo_data,
   input  logic         in_udo_valid_wr,
   input  logic         in_udo_valid,
   output logic         port0_data_wr,
   output logic [133:0] port0_data,
   output logic         port0_valid_wr,
   output logic         port0_valid,
   input  logic         port0_ready,
   output logic         port1_data_wr,
   output logic [133:0] port1_data,
   output logic         port1_valid_wr,
   output logic         port1_valid,
   input  logic         port1_ready,
   output logic [7:0]   pktout_usedw_0,
   output logic [7:0]   pktout_usedw_1,
   output logic [31:0]  udo_pktin_cnt,
   output logic [31:0]  udo_port0out_cnt,
   output logic [31:0]  udo_port1out_cnt,
   output logic [31:0]  udo_discard_cnt
);
   localparam logic [DATA_AW:0] DDEPTH = (DATA_AW+1)'(2**DATA_AW);
   localparam logic [DATA_AW:0] MAXF   = (DATA_AW+1)'(MAX_PKT_FLITS);
   localparam logic [PKT_AW:0]  PDEPTH = (PKT_AW+1)'(2**PKT_AW);

   // Registered capture of the ingress bus; the FSM acts on these.
   logic         in_wr_q, in_vwr_q, in_valid_q;
   logic [133:0] in_data_q;
   ing_state_t   ist_q, ist_d;
   logic [1:0]   sel_q, sel_d, sel_now, admit, data_we, pkt_we, rdy;
   logic [31:0]  pktin_q, pktin_d, disc_q, disc_d;
   logic [1:0]   ftype;
   logic         is_head;
   logic [1:0]   eg_wr, eg_vwr;
   logic [133:0] eg_dat [2];
   logic [7:0]   eg_used [2];
   logic [31:0]  eg_cnt [2];

   assign ftype   = in_data_q[133:132];
   assign is_head = in_wr_q && ftype == HEAD;
   assign sel_now = in_data_q[OUTPORT_HI:OUTPORT_LO] & admit;
   assign rdy     = {port1_ready, port0_ready};

   always_comb begin
      ist_d   = ist_q;
      sel_d   = sel_q;
      pktin_d = pktin_q;
      disc_d  = disc_q;
      data_we = 2'b00;
      pkt_we  = 2'b00;
      if (ist_q == I_IDLE && is_head) begin
         sel_d   = sel_now;
         data_we = sel_now;
         pktin_d = pktin_q + 32'd1;
         disc_d  = disc_q + 32'(sel_now == 2'b00);
         ist_d   = (sel_now != 2'b00) ? I_WRITE : I_DROP;
      end else if (ist_q == I_WRITE && in_wr_q) begin
         // a stray head inside a packet is not stored
         data_we = (ftype == BODY || ftype == TAIL) ? sel_q : 2'b00;
         pkt_we  = in_vwr_q ? sel_q : 2'b00;
         ist_d   = in_vwr_q ? I_IDLE : I_WRITE;
      end else if (ist_q == I_DROP && in_wr_q && in_vwr_q) begin
         ist_d = I_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_wr_q    <= 1'b0;
         in_vwr_q   <= 1'b0;
         in_valid_q <= 1'b0;
         in_data_q  <= '0;
         ist_q      <= I_IDLE;
         sel_q      <= 2'b00;
         pktin_q    <= '0;
         disc_q     <= '0;
      end else begin
         in_wr_q    <= in_udo_data_wr;
         in_vwr_q   <= in_udo_valid_wr;
         in_valid_q <= in_udo_valid;
         in_data_q  <= in_udo_data;
         ist_q      <= ist_d;
         sel_q      <= sel_d;
         pktin_q    <= pktin_d;
         disc_q     <= disc_d;
      end
   end

   for (genvar n = 0; n < 2; n++) begin : g_eg
      logic [DATA_AW:0] d_used, d_free;
      logic [PKT_AW:0]  p_used;
      logic [133:0]     d_rdata;
      logic             d_empty, p_empty, p_desc, d_rd, p_rd, tail;
      eg_state_t        st_q, st_d;
      logic             dv_q, dv_d, wr_q, wr_d, vwr_q, vwr_d;
      logic [133:0]     dat_q, dat_d;
      logic [31:0]      cnt_q, cnt_d;

      udo_fifo #(.W(134), .AW(DATA_AW)) u_data (
         .clk(clk), .rst(rst), .wr(data_we[n]), .wdata(in_data_q),
         .rd(d_rd), .rdata(d_rdata), .empty(d_empty), .usedw(d_used)
      );
      udo_fifo #(.W(1), .AW(PKT_AW)) u_pkt (
         .clk(clk), .rst(rst), .wr(pkt_we[n]), .wdata(in_valid_q),
         .rd(p_rd), .rdata(p_desc), .empty(p_empty), .usedw(p_used)
      );

      // room for a worst-case packet guarantees the data FIFO never overflows
      assign d_free   = DDEPTH - d_used;
      assign admit[n] = (d_free >= MAXF) && (p_used != PDEPTH);
      assign tail     = d_rdata[133:132] == TAIL;

      always_comb begin
         st_d  = st_q;
         dv_d  = dv_q;
         p_rd  = 1'b0;
         d_rd  = 1'b0;
         wr_d  = 1'b0;
         vwr_d = 1'b0;
         dat_d = dat_q;
         cnt_d = cnt_q;
         if (st_q == E_IDLE) begin
            p_rd = !p_empty;
            dv_d = p_empty ? dv_q : p_desc;
            st_d = p_empty ? E_IDLE : E_SEND;
         end else begin
            // discarded packets flush at full rate, ignoring ready
            d_rd  = (!dv_q || rdy[n]) && !d_empty;
            wr_d  = d_rd && dv_q;
            vwr_d = wr_d && tail;
            dat_d = wr_d ? d_rdata : dat_q;
            cnt_d = cnt_q + 32'(vwr_d);
            st_d  = (d_rd && tail) ? E_IDLE : E_SEND;
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            st_q  <= E_IDLE;
            dv_q  <= 1'b0;
            wr_q  <= 1'b0;
            vwr_q <= 1'b0;
            dat_q <= '0;
            cnt_q <= '0;
         end else begin
            st_q  <= st_d;
            dv_q  <= dv_d;
            wr_q  <= wr_d;
            vwr_q <= vwr_d;
            dat_q <= dat_d;
            cnt_q <= cnt_d;
         end
      end

      assign eg_wr[n]   = wr_q;
      assign eg_vwr[n]  = vwr_q;
      assign eg_dat[n]  = dat_q;
      assign eg_cnt[n]  = cnt_q;
      assign eg_used[n] = d_used[DATA_AW] ? 8'hFF : 8'(d_used[DATA_AW-1:0]);
   end

   assign port0_data_wr    = eg_wr[0];
   assign port0_data       = eg_dat[0];
   assign port0_valid_wr   = eg_vwr[0];
   assign port0_valid      = eg_vwr[0];
   assign port1_data_wr    = eg_wr[1];
   assign port1_data       = eg_dat[1];
   assign port1_valid_wr   = eg_vwr[1];
   assign port1_valid      = eg_vwr[1];
   assign pktout_usedw_0   = eg_used[0];
   assign pktout_usedw_1   = eg_used[1];
   assign udo_port0out_cnt = eg_cnt[0];
   assign udo_port1out_cnt = eg_cnt[1];
   assign udo_pktin_cnt    = pktin_q;
   assign udo_discard_cnt  = disc_q;
endmodule

// File: tb/tb_udo.sv
// tb_udo: directed table-driven bench for the udo dispatcher.
module tb_udo;
   import udo_pkg::*;

   logic         clk, rst;
   logic         in_udo_data_wr, in_udo_valid_wr, in_udo_valid;
   logic [133:0] in_udo_data;
   logic         port0_data_wr, port0_valid_wr, port0_valid, port0_ready;
   logic         port1_data_wr, port1_valid_wr, port1_valid, port1_ready;
   logic [133:0] port0_data, port1_data;
   logic [7:0]   pktout_usedw_0, pktout_usedw_1;
   logic [31:0]  udo_pktin_cnt, udo_port0out_cnt, udo_port1out_cnt, udo_discard_cnt;

   udo dut (
      .clk(clk), .rst(rst),
      .in_udo_data_wr(in_udo_data_wr), .in_udo_data(in_udo_data),
      .in_udo_valid_wr(in_udo_valid_wr), .in_udo_valid(in_udo_valid),
      .port0_data_wr(port0_data_wr), .port0_data(port0_data),
      .port0_valid_wr(port0_valid_wr), .port0_valid(port0_valid), .port0_ready(port0_ready),
      .port1_data_wr(port1_data_wr), .port1_data(port1_data),
      .port1_valid_wr(port1_valid_wr), .port1_valid(port1_valid), .port1_ready(port1_ready),
      .pktout_usedw_0(pktout_usedw_0), .pktout_usedw_1(pktout_usedw_1),
      .udo_pktin_cnt(udo_pktin_cnt), .udo_port0out_cnt(udo_port0out_cnt),
      .udo_port1out_cnt(udo_port1out_cnt), .udo_discard_cnt(udo_discard_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt = 0, total_cnt = 0;
   int e_pktin = 0, e_disc = 0, e_c0 = 0, e_c1 = 0;
   logic [133:0] q0 [$], q1 [$];
   int vw0 = 0, vw1 = 0;

   always @(negedge clk) begin
      if (port0_data_wr) q0.push_back(port0_data);
      if (port1_data_wr) q1.push_back(port1_data);
      if (port0_valid_wr && port0_valid) vw0++;
      if (port1_valid_wr && port1_valid) vw1++;
   end

   typedef struct {
      int n; logic [1:0] bm; logic v; int e0; int e1; int ev0; int ev1; int ed;
   } vec_t;
   vec_t tbl [6];

   task automatic chk(string nm, logic [133:0] act, logic [133:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic logic [133:0] mkflit(int i, int n, logic [1:0] bm, int id);
      logic [133:0] d;
      d = '0;
      d[133:132] = (i == 0) ? HEAD : ((i == n - 1) ? TAIL : BODY);
      d[131:128] = 4'(i % 3);
      d[121:120] = bm;
      d[31:16]   = 16'(id);
      d[15:0]    = 16'(i);
      return d;
   endfunction

   task automatic drive(int i, int n, logic [1:0] bm, logic v, int id);
      @(negedge clk);
      in_udo_data_wr  = 1'b1;
      in_udo_data     = mkflit(i, n, bm, id);
      in_udo_valid_wr = (i == n - 1);
      in_udo_valid    = (i == n - 1) ? v : 1'b0;
   endtask

   task automatic idle_in();
      @(negedge clk);
      in_udo_data_wr  = 1'b0;
      in_udo_valid_wr = 1'b0;
      in_udo_valid    = 1'b0;
   endtask

   task automatic send_pkt(int n, logic [1:0] bm, logic v, int id);
      for (int i = 0; i < n; i++) drive(i, n, bm, v, id);
      idle_in();
   endtask

   task automatic clr();
      @(posedge clk);
      q0.delete();
      q1.delete();
      vw0 = 0;
      vw1 = 0;
   endtask

   task automatic chk_flits(string nm, int p, int n, logic [1:0] bm, int id, int off);
      for (int i = 0; i < n; i++) begin
         logic [133:0] g;
         if (p == 0) g = (off + i < q0.size()) ? q0[off + i] : '0;
         else        g = (off + i < q1.size()) ? q1[off + i] : '0;
         chk($sformatf("%s[%0d]", nm, i), g, mkflit(i, n, bm, id));
      end
   endtask

   task automatic chk_cnts(string nm);
      chk({nm, "_pktin"}, udo_pktin_cnt, e_pktin);
      chk({nm, "_disc"}, udo_discard_cnt, e_disc);
      chk({nm, "_c0"}, udo_port0out_cnt, e_c0);
      chk({nm, "_c1"}, udo_port1out_cnt, e_c1);
   endtask

   task automatic chk_zero(string nm);
      chk({nm, "_wr0"}, port0_data_wr, 0);
      chk({nm, "_wr1"}, port1_data_wr, 0);
      chk({nm, "_vwr0"}, port0_valid_wr, 0);
      chk({nm, "_vwr1"}, port1_valid_wr, 0);
      chk({nm, "_dat0"}, port0_data, 0);
      chk({nm, "_used0"}, pktout_usedw_0, 0);
      chk({nm, "_used1"}, pktout_usedw_1, 0);
      chk_cnts(nm);
   endtask

   logic [8:0] rp;
   int lat;

   initial begin
      tbl[0] = '{4, 2'b01, 1'b1, 4, 0, 1, 0, 0};
      tbl[1] = '{3, 2'b11, 1'b1, 3, 3, 1, 1, 0};
      tbl[2] = '{5, 2'b01, 1'b0, 0, 0, 0, 0, 0};
      tbl[3] = '{2, 2'b10, 1'b1, 0, 2, 0, 1, 0};
      tbl[4] = '{3, 2'b00, 1'b1, 0, 0, 0, 0, 1};
      tbl[5] = '{6, 2'b11, 1'b0, 0, 0, 0, 0, 0};
      rp = 9'b011110010;
      rst = 1'b1;
      in_udo_data_wr = 1'b0; in_udo_valid_wr = 1'b0; in_udo_valid = 1'b0; in_udo_data = '0;
      port0_ready = 1'b1; port1_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // tail-in to head-out latency
      clr();
      drive(0, 2, 2'b01, 1'b1, 50);
      drive(1, 2, 2'b01, 1'b1, 50);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) begin
            in_udo_data_wr = 1'b0; in_udo_valid_wr = 1'b0; in_udo_valid = 1'b0;
         end
         if (port0_data_wr && lat == 0) lat = k;
      end
      chk("latency", lat, 4);
      chk_flits("lat_flit", 0, 2, 2'b01, 50, 0);
      e_pktin++; e_c0++;

      for (int k = 0; k < 6; k++) begin
         clr();
         send_pkt(tbl[k].n, tbl[k].bm, tbl[k].v, 100 + k);
         repeat (20) @(negedge clk);
         e_pktin++; e_disc += tbl[k].ed; e_c0 += tbl[k].ev0; e_c1 += tbl[k].ev1;
         chk($sformatf("v%0d_n0", k), q0.size(), tbl[k].e0);
         chk($sformatf("v%0d_n1", k), q1.size(), tbl[k].e1);
         chk($sformatf("v%0d_vw0", k), vw0, tbl[k].ev0);
         chk($sformatf("v%0d_vw1", k), vw1, tbl[k].ev1);
         if (tbl[k].e0 > 0) chk_flits($sformatf("v%0d_f0", k), 0, tbl[k].n, tbl[k].bm, 100 + k, 0);
         if (tbl[k].e1 > 0) chk_flits($sformatf("v%0d_f1", k), 1, tbl[k].n, tbl[k].bm, 100 + k, 0);
         chk($sformatf("v%0d_used0", k), pktout_usedw_0, 0);
         chk($sformatf("v%0d_used1", k), pktout_usedw_1, 0);
         chk_cnts($sformatf("v%0d", k));
      end

      // backpressure on port 1: ready 1,0,0,1,1,1,1 after a stalled start
      port1_ready = 1'b0;
      clr();
      send_pkt(5, 2'b10, 1'b1, 200);
      e_pktin++; e_c1++;
      repeat (8) @(negedge clk);
      chk("bp_hold", q1.size(), 0);
      for (int j = 0; j <= 8; j++) begin
         if (j > 0) @(negedge clk);
         chk($sformatf("bp_wr%0d", j), port1_data_wr, rp[j]);
         if (j < 8) port1_ready = rp[j + 1];
         else port1_ready = 1'b1;
      end
      repeat (3) @(negedge clk);
      chk("bp_n", q1.size(), 5);
      chk("bp_vw", vw1, 1);
      chk_flits("bp_flit", 1, 5, 2'b10, 200, 0);

      // admission: port 0 filled to 161 flits rejects the next packet
      port0_ready = 1'b0;
      clr();
      send_pkt(96, 2'b01, 1'b1, 300);
      send_pkt(65, 2'b01, 1'b1, 301);
      e_pktin += 2;
      repeat (4) @(negedge clk);
      chk("adm_fill", pktout_usedw_0, 161);
      send_pkt(4, 2'b01, 1'b1, 302);
      e_pktin++; e_disc++;
      repeat (4) @(negedge clk);
      chk("adm_used", pktout_usedw_0, 161);
      chk("adm_disc", udo_discard_cnt, e_disc);
      // broadcast with only port 1 admitted goes to port 1, no discard
      send_pkt(3, 2'b11, 1'b1, 303);
      e_pktin++; e_c1++;
      repeat (12) @(negedge clk);
      chk("bc_n1", q1.size(), 3);
      chk("bc_n0", q0.size(), 0);
      chk_flits("bc_flit", 1, 3, 2'b11, 303, 0);
      chk("bc_disc", udo_discard_cnt, e_disc);
      chk("bc_used0", pktout_usedw_0, 161);
      // port 1: 160 flits still admits a worst-case packet; 256 reads as 255
      port1_ready = 1'b0;
      send_pkt(96, 2'b10, 1'b1, 304);
      send_pkt(64, 2'b10, 1'b1, 305);
      repeat (4) @(negedge clk);
      chk("sat_160", pktout_usedw_1, 160);
      send_pkt(96, 2'b10, 1'b1, 306);
      e_pktin += 3; e_c1 += 3;
      repeat (4) @(negedge clk);
      chk("sat_255", pktout_usedw_1, 255);
      chk("sat_disc", udo_discard_cnt, e_disc);
      port0_ready = 1'b1;
      port1_ready = 1'b1;
      e_c0 += 2;
      repeat (420) @(negedge clk);
      chk("drain_used0", pktout_usedw_0, 0);
      chk("drain_used1", pktout_usedw_1, 0);
      chk("drain_n0", q0.size(), 161);
      chk("drain_n1", q1.size(), 259);
      chk_flits("drain_a", 0, 96, 2'b01, 300, 0);
      chk_flits("drain_b", 0, 65, 2'b01, 301, 96);
      chk_flits("drain_c", 1, 96, 2'b10, 306, 163);
      chk_cnts("drain");

      // reset during the second flit of a six-flit packet
      clr();
      drive(0, 6, 2'b01, 1'b1, 400);
      drive(1, 6, 2'b01, 1'b1, 400);
      rst = 1'b1;
      e_pktin = 0; e_disc = 0; e_c0 = 0; e_c1 = 0;
      repeat (2) @(negedge clk);
      chk_zero("mid_rst");
      rst = 1'b0;
      for (int i = 2; i < 6; i++) drive(i, 6, 2'b01, 1'b1, 400);
      idle_in();
      q0.delete();
      vw0 = 0;
      send_pkt(3, 2'b01, 1'b1, 401);
      e_pktin = 1; e_c0 = 1;
      repeat (15) @(negedge clk);
      chk("post_n0", q0.size(), 3);
      chk("post_vw0", vw0, 1);
      chk_flits("post_flit", 0, 3, 2'b01, 401, 0);
      chk_cnts("post");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
